// File: rtl/mem_access_unit.sv
// Memory access unit: MAR/MDR pair with a request FSM driving a single-port RAM.
// Optional MAU_TIMEOUT_EN adds a per-access wait limit and a sticky err flag.
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic [ADDR_W-1:0] mar_out,
    output logic [DATA_W-1:0] mdr_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    // state   | meaning
    // IDLE    | waiting for rd_req / wr_req, MAR/MDR loadable
    // RD_WAIT | mem_rd asserted, waiting for mem_ready
    // WR_WAIT | mem_wr asserted, waiting for mem_ready
    // DONE    | one-cycle done pulse, requests ignored, MAR/MDR loadable
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;

`ifdef MAU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    logic             wait_expired;

    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign err          = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            mar      <= '0;
            mdr      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
`ifdef MAU_TIMEOUT_EN
            wait_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mar_in) mar <= bus_in[ADDR_W-1:0];
                    if (mdr_in) mdr <= bus_in;
                    // A simultaneous write request is dropped when a read wins.
                    if (rd_req) begin
                        state  <= RD_WAIT;
                        mem_rd <= 1'b1;
                        busy   <= 1'b1;
`ifdef MAU_TIMEOUT_EN
                        wait_cnt <= '0;
                        err_q    <= 1'b0;
`endif
                    end else if (wr_req) begin
                        state  <= WR_WAIT;
                        mem_wr <= 1'b1;
                        busy   <= 1'b1;
`ifdef MAU_TIMEOUT_EN
                        wait_cnt <= '0;
                        err_q    <= 1'b0;
`endif
                    end
                end
                RD_WAIT: begin
                    if (mem_ready) begin
                        mdr    <= mem_rdata;
                        state  <= DONE;
                        mem_rd <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
`ifdef MAU_TIMEOUT_EN
                    else if (wait_expired) begin
                        state  <= DONE;
                        mem_rd <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        err_q  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                WR_WAIT: begin
                    if (mem_ready) begin
                        state  <= DONE;
                        mem_wr <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
`ifdef MAU_TIMEOUT_EN
                    else if (wait_expired) begin
                        state  <= DONE;
                        mem_wr <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        err_q  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (mar_in) mar <= bus_in[ADDR_W-1:0];
                    if (mdr_in) mdr <= bus_in;
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    assign mar_out   = mar;
    assign mdr_out   = mdr;
    assign mem_addr  = mar;
    assign mem_wdata = mdr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of accesses against a RAM model plus
// directed sequences for back-to-back timing, clr abort and (MAU_TIMEOUT_EN) timeout.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] bus_in;
    logic        mar_in, mdr_in, rd_req, wr_req;
    logic [8:0]  mar_out, mem_addr;
    logic [31:0] mdr_out, mem_wdata, mem_rdata;
    logic        busy, done, err, mem_rd, mem_wr, mem_ready;

    logic [31:0] ram [0:511];
    logic [8:0]  exp_mar;
    logic [31:0] exp_mdr;
    int          vec_cnt = 0;
    int          miscompares = 0;

    typedef struct {
        bit          is_rd;
        logic [8:0]  addr;
        logic [31:0] data;
    } sb_t;
    sb_t sb [$];

    typedef struct {
        logic [31:0] bus_addr;
        logic [31:0] data;
        bit          is_rd;
        int          waits;
        bit          both;
        bit          poke;
    } vec_t;
    vec_t vecs [8];

    mem_access_unit dut (
        .clk       (clk),
        .clr       (clr),
        .bus_in    (bus_in),
        .mar_in    (mar_in),
        .mdr_in    (mdr_in),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .mar_out   (mar_out),
        .mdr_out   (mdr_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_wr && mem_ready) ram[mem_addr] = mem_wdata;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic load_mar(input logic [31:0] v);
        @(negedge clk);
        bus_in = v;
        mar_in = 1'b1;
        @(negedge clk);
        mar_in  = 1'b0;
        exp_mar = v[8:0];
        check("mar_load", {23'd0, mar_out}, {23'd0, exp_mar});
        check("mem_addr", {23'd0, mem_addr}, {23'd0, exp_mar});
    endtask

    task automatic load_mdr(input logic [31:0] v);
        @(negedge clk);
        bus_in = v;
        mdr_in = 1'b1;
        @(negedge clk);
        mdr_in  = 1'b0;
        exp_mdr = v;
        check("mdr_load", mdr_out, exp_mdr);
        check("mem_wdata", mem_wdata, exp_mdr);
    endtask

    task automatic access(input bit is_rd, input int waits, input bit both,
                          input bit poke, input logic [31:0] data);
        sb_t e;
        int  k, rd_cyc, wr_cyc;
        if (is_rd) ram[exp_mar] = data;
        e.is_rd = is_rd;
        e.addr  = exp_mar;
        e.data  = data;
        sb.push_back(e);
        @(negedge clk);
        rd_req    = is_rd | both;
        wr_req    = !is_rd | both;
        mem_ready = 1'b0;
        @(negedge clk);
        rd_req = 1'b0;
        wr_req = 1'b0;
        k = 0; rd_cyc = 0; wr_cyc = 0;
        while (busy && k < 100) begin
            if (mem_rd) rd_cyc++;
            if (mem_wr) wr_cyc++;
            mem_ready = (k >= waits);
            if (poke) begin
                bus_in = 32'hFFFF_FFFF;
                mdr_in = 1'b1;
                mar_in = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        mem_ready = 1'b0;
        mdr_in    = 1'b0;
        mar_in    = 1'b0;
        check("rd_strobe_cycles", rd_cyc, is_rd ? waits + 1 : 0);
        check("wr_strobe_cycles", wr_cyc, is_rd ? 0 : waits + 1);
        check("done_latency", k, waits + 1);
        check("done_pulse", done, 1'b1);
        check("busy_in_done", busy, 1'b0);
        e = sb.pop_front();
        if (e.is_rd) begin
            check("read_mdr", mdr_out, e.data);
            exp_mdr = e.data;
        end else begin
            check("ram_written", ram[e.addr], e.data);
            check("write_mdr_kept", mdr_out, e.data);
        end
        check("mar_stable", {23'd0, mar_out}, {23'd0, e.addr});
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("err_clear", err, 1'b0);
    endtask

    initial begin
        logic [4:0] pat_rd;
        logic [4:0] pat_done;
        int         k;

        for (int i = 0; i < 512; i++) ram[i] = 32'h0;
        vecs[0] = '{32'h0000_0005, 32'hDEAD_BEEF, 1'b1, 0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_01FF, 32'h1234_5678, 1'b0, 3, 1'b0, 1'b0};
        vecs[2] = '{32'hABCD_E0FF, 32'hCAFE_F00D, 1'b1, 2, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0100, 32'hA5A5_A5A5, 1'b0, 0, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0042, 32'h0BAD_CAFE, 1'b1, 0, 1'b1, 1'b0};
        vecs[5] = '{32'h0000_0077, 32'h1357_9BDF, 1'b1, 2, 1'b0, 1'b1};
        vecs[6] = '{32'hFFFF_FE00, 32'h8000_0001, 1'b0, 1, 1'b0, 1'b1};
        vecs[7] = '{32'h0000_01FF, 32'h1234_5678, 1'b1, 1, 1'b0, 1'b0};

        clr = 1'b1; bus_in = '0; mar_in = 0; mdr_in = 0;
        rd_req = 0; wr_req = 0; mem_ready = 0;
        @(negedge clk);
        check("rst_mar", {23'd0, mar_out}, 32'h0);
        check("rst_mdr", mdr_out, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        clr = 1'b0;
        exp_mar = '0;
        exp_mdr = '0;

        for (int i = 0; i < 8; i++) begin
            load_mar(vecs[i].bus_addr);
            if (!vecs[i].is_rd) load_mdr(vecs[i].data);
            access(vecs[i].is_rd, vecs[i].waits, vecs[i].both, vecs[i].poke, vecs[i].data);
        end
        check("ram_1ff_kept", ram[9'h1FF], 32'h1234_5678);

        // rd_req held high with zero wait: strobe, done, idle, strobe, done
        pat_rd   = 5'b01001;
        pat_done = 5'b10010;
        load_mar(32'h0000_0033);
        ram[9'h033] = 32'h6666_9999;
        @(negedge clk);
        rd_req    = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b2b_mem_rd", mem_rd, pat_rd[i]);
            check("b2b_done", done, pat_done[i]);
        end
        rd_req    = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        check("b2b_mdr", mdr_out, 32'h6666_9999);

        // clr in the middle of a read abandons it
        load_mdr(32'h55AA_55AA);
        load_mar(32'h0000_0010);
        ram[9'h010] = 32'h7777_7777;
        @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        check("pre_clr_mem_rd", mem_rd, 1'b1);
        #2 clr = 1'b1;
        #1;
        check("clr_mem_rd", mem_rd, 1'b0);
        check("clr_busy", busy, 1'b0);
        check("clr_mdr", mdr_out, 32'h0);
        check("clr_mar", {23'd0, mar_out}, 32'h0);
        @(negedge clk);
        clr       = 1'b0;
        mem_ready = 1'b1;
        exp_mar   = '0;
        exp_mdr   = '0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy) k++;
        end
        mem_ready = 1'b0;
        check("clr_no_done", k, 0);
        check("clr_mdr_after", mdr_out, 32'h0);

`ifdef MAU_TIMEOUT_EN
        load_mar(32'h0000_0003);
        load_mdr(32'h0BAD_F00D);
        ram[9'h003] = 32'h1111_2222;
        @(negedge clk);
        rd_req    = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        rd_req = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("to_wait_cycles", k, 15);
        check("to_done", done, 1'b1);
        check("to_err", err, 1'b1);
        check("to_mdr_kept", mdr_out, 32'h0BAD_F00D);
        @(negedge clk);
        check("to_err_sticky", err, 1'b1);
        access(1'b1, 0, 1'b0, 1'b0, 32'h3333_4444);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
